// File: rtl/ibex_rf_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : ibex_rf_wb_queue
// Description : Write-back queue in front of the flop-based register file.
//               Accepts register writes from the LSU/multicycle path (older)
//               and the execute stage (younger) through valid/ready
//               handshakes. It holds them in a small in-order circular buffer
//               and drains exactly one write per cycle onto the single
//               register-file write port.
//               Optional forwarding (macro IBEX_RF_WB_FWD_EN) returns the
//               youngest queued data for three read addresses. Without the
//               macro, no search logic is built and the core must stall ID
//               while busy_o is high.
// Ports       : clk_i, rst_ni (async, active-low)
//               lsu_valid_i/lsu_waddr_i/lsu_wdata_i/lsu_ready_o   LSU writes
//               ex_valid_i/ex_waddr_i/ex_wdata_i/ex_dummy_i/ex_ready_o
//                                                                  EX writes
//               rf_waddr_o/rf_wdata_o/rf_we_o/rf_dummy_wb_o       RF port
//               fwd_raddr_{a,b,rd}_i, fwd_hit_{a,b,rd}_o,
//               fwd_data_{a,b,rd}_o                               forwarding
//               busy_o                                            non-empty
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_rf_wb_queue #(
    parameter bit                   RV32E       = 1'b0,
    parameter int unsigned          DataWidth   = 32,
    parameter int unsigned          Depth       = 4,
    parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 lsu_valid_i,
    input  logic [4:0]           lsu_waddr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic                 lsu_ready_o,

    input  logic                 ex_valid_i,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    input  logic                 ex_dummy_i,
    output logic                 ex_ready_o,

    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 rf_we_o,
    output logic                 rf_dummy_wb_o,

    input  logic [4:0]           fwd_raddr_a_i,
    input  logic [4:0]           fwd_raddr_b_i,
    input  logic [4:0]           fwd_raddr_rd_i,
    output logic                 fwd_hit_a_o,
    output logic                 fwd_hit_b_o,
    output logic                 fwd_hit_rd_o,
    output logic [DataWidth-1:0] fwd_data_a_o,
    output logic [DataWidth-1:0] fwd_data_b_o,
    output logic [DataWidth-1:0] fwd_data_rd_o,

    output logic                 busy_o
);

    localparam int unsigned   PtrW     = $clog2(Depth);
    localparam int unsigned   CntW     = $clog2(Depth + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    // Storage: one {addr, data, dummy} triple per slot.
    logic [4:0]           addr_q  [Depth];
    logic [DataWidth-1:0] data_q  [Depth];
    logic                 dummy_q [Depth];

    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [CntW-1:0] count_q;

    logic [CntW-1:0] free;
    logic            lsu_fire;
    logic            ex_fire;
    logic            lsu_push;
    logic            ex_push;
    logic [PtrW-1:0] ex_slot;
    logic [CntW-1:0] num_push;
    logic            pop;

    // A write survives only if it targets a real, writable register. Dummy
    // writes to x0 are kept so the RF sees the dummy-instruction activity.
    function automatic logic keep_write(input logic [4:0] addr,
                                        input logic       dummy);
        keep_write = ((addr != 5'd0) || dummy) && !(RV32E && addr[4]);
    endfunction

    // Readiness depends only on the registered count: a same-cycle pop does
    // not free a slot, which keeps ready off the drain path.
    assign free        = DepthCnt - count_q;
    assign lsu_ready_o = (free != '0);
    assign lsu_fire    = lsu_valid_i & lsu_ready_o;
    // free >= 1 + lsu_fire, written as a strict compare.
    assign ex_ready_o  = (free > CntW'(lsu_fire));
    assign ex_fire     = ex_valid_i & ex_ready_o;

    assign lsu_push = lsu_fire & keep_write(lsu_waddr_i, 1'b0);
    assign ex_push  = ex_fire  & keep_write(ex_waddr_i, ex_dummy_i);

    // LSU is older, so it takes the first free slot and EX lands after it.
    assign ex_slot  = wr_ptr_q + PtrW'(lsu_push);
    assign num_push = CntW'(lsu_push) + CntW'(ex_push);
    assign pop      = (count_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Depth is a power of two, so pointer truncation is the wrap.
            rd_ptr_q <= rd_ptr_q + PtrW'(pop);
            wr_ptr_q <= wr_ptr_q + PtrW'(num_push);
            count_q  <= count_q + num_push - CntW'(pop);
        end
    end

    // Payload storage needs no reset: the count qualifies every slot.
    always_ff @(posedge clk_i) begin
        if (lsu_push) begin
            addr_q[wr_ptr_q]  <= lsu_waddr_i;
            data_q[wr_ptr_q]  <= lsu_wdata_i;
            dummy_q[wr_ptr_q] <= 1'b0;
        end
        if (ex_push) begin
            addr_q[ex_slot]  <= ex_waddr_i;
            data_q[ex_slot]  <= ex_wdata_i;
            dummy_q[ex_slot] <= ex_dummy_i;
        end
    end

    // Head of the queue drives the register-file write port directly.
    assign rf_we_o       = pop;
    assign rf_waddr_o    = pop ? addr_q[rd_ptr_q] : 5'd0;
    assign rf_wdata_o    = pop ? data_q[rd_ptr_q] : WordZeroVal;
    assign rf_dummy_wb_o = pop & dummy_q[rd_ptr_q];
    assign busy_o        = pop;

`ifdef IBEX_RF_WB_FWD_EN
    // Slots listed by age, oldest first, with their occupancy.
    logic [PtrW-1:0] age_idx   [Depth];
    logic [Depth-1:0] age_valid;

    for (genvar i = 0; i < Depth; i++) begin : g_age
        assign age_idx[i]   = rd_ptr_q + PtrW'(i);
        assign age_valid[i] = (CntW'(i) < count_q) & ~dummy_q[age_idx[i]]
                              & (addr_q[age_idx[i]] != 5'd0);
    end

    logic [4:0]           fwd_raddr [3];
    logic [2:0]           fwd_hit;
    logic [DataWidth-1:0] fwd_data  [3];

    assign fwd_raddr[0] = fwd_raddr_a_i;
    assign fwd_raddr[1] = fwd_raddr_b_i;
    assign fwd_raddr[2] = fwd_raddr_rd_i;

    // Scanning oldest to youngest lets the youngest match overwrite.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            fwd_hit[p]  = 1'b0;
            fwd_data[p] = WordZeroVal;
            for (int i = 0; i < Depth; i++) begin
                if (age_valid[i] && (addr_q[age_idx[i]] == fwd_raddr[p])) begin
                    fwd_hit[p]  = 1'b1;
                    fwd_data[p] = data_q[age_idx[i]];
                end
            end
        end
    end

    assign fwd_hit_a_o   = fwd_hit[0];
    assign fwd_hit_b_o   = fwd_hit[1];
    assign fwd_hit_rd_o  = fwd_hit[2];
    assign fwd_data_a_o  = fwd_data[0];
    assign fwd_data_b_o  = fwd_data[1];
    assign fwd_data_rd_o = fwd_data[2];
`else
    logic [14:0] unused_fwd_raddr;
    assign unused_fwd_raddr = {fwd_raddr_a_i, fwd_raddr_b_i, fwd_raddr_rd_i};

    assign fwd_hit_a_o   = 1'b0;
    assign fwd_hit_b_o   = 1'b0;
    assign fwd_hit_rd_o  = 1'b0;
    assign fwd_data_a_o  = WordZeroVal;
    assign fwd_data_b_o  = WordZeroVal;
    assign fwd_data_rd_o = WordZeroVal;
`endif

endmodule
`default_nettype wire

// File: doc/ibex_rf_wb_queue.md
Name: ibex_rf_wb_queue

Overview:
- Write-back side producer for the flop-based register file.
- Accepts register writes from two sources through valid/ready handshakes: LSU/multicycle (older) and execute (younger).
- Buffers them in a small in-order queue and drains exactly one write per cycle onto the register file's single write port.
- Provides combinational forwarding of still-queued data to three read addresses (a, b, rd) so the ID stage never reads stale register contents.

Parameters:
- RV32E, 0, when 1 only x0..x15 exist; writes to x16..x31 are accepted and dropped.
- DataWidth, 32, register data width.
- Depth, 4, queue entries; power of two, 2..8.
- WordZeroVal, '0, value driven on rf_wdata_o and fwd data outputs when idle/no hit.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- lsu_valid_i  in  1  LSU write request
- lsu_waddr_i  in  5  LSU destination register
- lsu_wdata_i  in  DataWidth  LSU write data
- lsu_ready_o  out  1  LSU request accepted this cycle
- ex_valid_i  in  1  execute write request
- ex_waddr_i  in  5  execute destination register
- ex_wdata_i  in  DataWidth  execute write data
- ex_dummy_i  in  1  request belongs to a dummy instruction
- ex_ready_o  out  1  execute request accepted this cycle
- rf_waddr_o  out  5  register file write address
- rf_wdata_o  out  DataWidth  register file write data
- rf_we_o  out  1  register file write enable
- rf_dummy_wb_o  out  1  current write is a dummy-instruction write
- fwd_raddr_a_i / fwd_raddr_b_i / fwd_raddr_rd_i  in  5 each  read addresses to check
- fwd_hit_a_o / fwd_hit_b_o / fwd_hit_rd_o  out  1 each  queued write pending for that address
- fwd_data_a_o / fwd_data_b_o / fwd_data_rd_o  out  DataWidth each  youngest queued data for that address
- busy_o  out  1  queue non-empty

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clock is clk_i. Reset empties the queue (rd/wr pointers and count to 0). Reset mid-operation discards all pending entries; no write is issued.
- Storage: circular buffer of Depth entries {addr, data, dummy} plus registered count (0..Depth).
- Readiness uses registered count only; there is no same-cycle pop credit. With free = Depth - count:
  - lsu_ready_o = (free >= 1).
  - ex_ready_o = (free >= 1 + (lsu_valid_i & lsu_ready_o)).
- Push order when both handshakes fire in one cycle: LSU entry first (older), then EX entry. Up to 2 pushes per cycle.
- Drop rule (handshake still completes, nothing enqueued):
  - waddr == 0 with dummy == 0 (LSU requests are never dummy);
  - RV32E=1 and waddr[4] == 1.
- Dummy EX writes to x0 are enqueued with dummy = 1.
- Drain: when count > 0, head drives rf_we_o=1, rf_waddr_o, rf_wdata_o and rf_dummy_wb_o combinationally from storage; head pops at the clock edge. Exactly one pop per cycle while non-empty.
- Idle (count == 0) outputs: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=WordZeroVal, rf_dummy_wb_o=0.
- Latency: request accepted in cycle N reaches the write port in cycle N+1 if the queue was empty; otherwise after all older entries.
- Count update: count_next = count + pushes - pop. Never exceeds Depth by construction. Pointers wrap modulo Depth.
- busy_o = (count != 0).
- Forwarding:
  - For each read address, search all valid entries (head included, since head is not yet in the register file this cycle).
  - Only entries with dummy == 0 and addr != 0 can match.
  - Youngest match wins: hit=1, data = that entry's data. No match: hit=0, data=WordZeroVal.
  - Same-cycle incoming requests are not forwarded.

Optional Feature:
- Macro: IBEX_RF_WB_FWD_EN.
- Defined: forwarding logic as described.
- Undefined: no search logic is built; all fwd_hit_*_o=0 and fwd_data_*_o=WordZeroVal; fwd_raddr_*_i are tied to an unused signal. The core must then stall ID while busy_o=1.

Test Plan:
- Single write: empty queue, lsu_valid_i=1, addr 5, data 0x1234 in cycle 0 -> lsu_ready_o=1; cycle 1 rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x1234; cycle 2 rf_we_o=0, busy_o=0.
- Dual push and order: LSU (x3, 0xA) and EX (x3, 0xB) in the same cycle with Depth=4 -> both ready; writes x3=0xA then x3=0xB on consecutive cycles; fwd_raddr_a_i=3 returns hit=1, data 0xB while both are queued.
- Full back-pressure: Depth=2, both sources valid every cycle -> after fill, ex_ready_o=0 whenever LSU accepted, lsu_ready_o=0 at count=2; no entry lost; rf_we_o high every cycle until drained.
- x0 and dummy handling: EX x0 with dummy=0 -> accepted, no rf_we_o. EX x0 with dummy=1, data 0x55 -> rf_we_o=1, rf_dummy_wb_o=1; fwd_raddr_a_i=0 -> hit=0.
- RV32E drop: RV32E=1, LSU write to x20 -> accepted, never written; busy_o stays 0.
- Reset mid-operation: 3 entries queued, assert rst_ni low -> immediately rf_we_o=0, busy_o=0, all hits 0; after release both readies are 1.
